// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared defaults and enums for the data-memory arbiter.
package dm_arb_pkg;

    localparam int unsigned DM_ADDR_W = 16;
    localparam int unsigned DM_DATA_W = 16;
    localparam int unsigned DM_LEN_W  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

endpackage

// File: rtl/dm_burst_agen.sv
// dm_burst_agen: DMA burst beat counter and address incrementer.
// Beat 0 is issued straight from the request fields; this block supplies
// the address for beats 1..len (base + index, wrapping modulo 2^ADDR_W).
module dm_burst_agen
    import dm_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DM_ADDR_W,
    parameter int unsigned LEN_W  = DM_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;

    // Latch burst parameters on load (index 1 is next), advance on each beat.
    always_comb begin
        base_d = base_q;
        len_d  = len_q;
        idx_d  = idx_q;
        if (load) begin
            base_d = base;
            len_d  = len;
            idx_d  = LEN_W'(1);
        end else if (step) begin
            idx_d = idx_q + LEN_W'(1);
        end
    end

    // Counter and latched parameter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            len_q  <= '0;
            idx_q  <= '0;
        end else begin
            base_q <= base_d;
            len_q  <= len_d;
            idx_q  <= idx_d;
        end
    end

    assign addr = base_q + ADDR_W'(idx_q);
    assign last = (idx_q == len_q);

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: single-port data-memory arbiter between CPU MEM stage and a
// burst DMA engine. Optional macro DM_ARB_RR_EN: alternate tie winners in
// IDLE (otherwise the CPU always wins ties and no last-winner flop exists).
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DM_ADDR_W,
    parameter int unsigned DATA_W = DM_DATA_W,
    parameter int unsigned LEN_W  = DM_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_base,
    input  logic [LEN_W-1:0]  dma_len,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              dma_done,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    logic              rv_q, rv_d;
    owner_e            rown_q, rown_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              tie_to_dma;
    logic              dma_win;
    logic              beat_we;
    logic              agen_load;
    logic              agen_step;
    logic              agen_last;
    logic              final_beat;
    logic [ADDR_W-1:0] agen_addr;

`ifdef DM_ARB_RR_EN
    owner_e last_q, last_d;
    assign tie_to_dma = (last_q == OWN_CPU);
`else
    assign tie_to_dma = 1'b0;
`endif

    assign dma_win = dma_req & (~cpu_req | tie_to_dma);

    dm_burst_agen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_agen (
        .clk  (clk),
        .rst  (rst),
        .load (agen_load),
        .step (agen_step),
        .base (dma_base),
        .len  (dma_len),
        .addr (agen_addr),
        .last (agen_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter BURST only for multi-beat wins; leave on last beat or abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dma_win && dma_len != '0) state_d = BURST;
            BURST:   if (!dma_req || agen_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant and memory-port steering; everything is suppressed while in reset.
    always_comb begin
        cpu_gnt   = 1'b0;
        dma_gnt   = 1'b0;
        agen_load = 1'b0;
        agen_step = 1'b0;
        beat_we   = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (dma_win) begin
                        dma_gnt   = 1'b1;
                        agen_load = 1'b1;
                        beat_we   = dma_we;
                        mem_addr  = dma_base;
                        mem_wdata = dma_wdata;
                    end else if (cpu_req) begin
                        cpu_gnt = 1'b1;
                        beat_we = cpu_we;
                    end
                end
                BURST: begin
                    if (dma_req) begin
                        dma_gnt   = 1'b1;
                        agen_step = 1'b1;
                        beat_we   = we_q;
                        mem_addr  = agen_addr;
                        mem_wdata = dma_wdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_re     = (cpu_gnt | dma_gnt) & ~beat_we;
    assign mem_we     = (cpu_gnt | dma_gnt) & beat_we;
    assign cpu_stall  = cpu_req & ~cpu_gnt;
    assign final_beat = dma_gnt & (((state_q == IDLE) & (dma_len == '0)) |
                                   ((state_q == BURST) & agen_last));

    assign cpu_rvalid = ~rst & rv_q & (rown_q == OWN_CPU);
    assign dma_rvalid = ~rst & rv_q & (rown_q == OWN_DMA);
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;
    assign dma_done   = ~rst & done_q;

    // Return-owner pipeline, latched burst direction, done pulse, last winner.
    always_comb begin
        rv_d   = mem_re;
        rown_d = dma_gnt ? OWN_DMA : OWN_CPU;
        we_d   = agen_load ? dma_we : we_q;
        done_d = final_beat;
`ifdef DM_ARB_RR_EN
        last_d = last_q;
        if (agen_load) begin
            last_d = OWN_DMA;
        end else if (cpu_gnt) begin
            last_d = OWN_CPU;
        end
`endif
    end

    // Datapath registers; reset discards in-flight returns and pending done.
    always_ff @(posedge clk) begin
        if (rst) begin
            rv_q   <= 1'b0;
            rown_q <= OWN_CPU;
            we_q   <= 1'b0;
            done_q <= 1'b0;
`ifdef DM_ARB_RR_EN
            last_q <= OWN_DMA;
`endif
        end else begin
            rv_q   <= rv_d;
            rown_q <= rown_d;
            we_q   <= we_d;
            done_q <= done_d;
`ifdef DM_ARB_RR_EN
            last_q <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: table-driven cycle vectors plus hand-written corner
// sequences; read returns are tracked in a scoreboard queue.
module tb_dm_arbiter;

`ifdef DM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        dma_req, dma_we;
    logic [15:0] dma_base, dma_wdata;
    logic [3:0]  dma_len;
    logic        dma_gnt, dma_rvalid, dma_done;
    logic [15:0] dma_rdata;
    logic        mem_re, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        logic        rst;
        logic        creq;
        logic        cwe;
        logic [15:0] caddr;
        logic        dreq;
        logic        dwe;
        logic [15:0] dbase;
        logic [3:0]  dlen;
        logic        ecg;
        logic        edg;
        logic [15:0] eaddr;
        logic        ewe;
        logic        edone;
    } vec_t;

    typedef struct {
        logic        own_dma;
        logic [15:0] data;
        int          cyc;
    } ret_t;

    vec_t tbl[$];
    ret_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dm_arbiter #(
        .ADDR_W (16),
        .DATA_W (16),
        .LEN_W  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_base   (dma_base),
        .dma_len    (dma_len),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rdata  (dma_rdata),
        .dma_rvalid (dma_rvalid),
        .dma_done   (dma_done),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    function automatic logic [15:0] mdl(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    // Memory model: read data appears one cycle after mem_re.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mdl(mem_addr);
    end

    function automatic vec_t mk(input logic r, input logic creq, input logic cwe,
                                input logic [15:0] caddr, input logic dreq,
                                input logic dwe, input logic [15:0] dbase,
                                input logic [3:0] dlen, input logic ecg,
                                input logic edg, input logic [15:0] eaddr,
                                input logic ewe, input logic edone);
        vec_t v;
        v.rst = r;     v.creq = creq; v.cwe = cwe;   v.caddr = caddr;
        v.dreq = dreq; v.dwe = dwe;   v.dbase = dbase; v.dlen = dlen;
        v.ecg = ecg;   v.edg = edg;   v.eaddr = eaddr; v.ewe = ewe;
        v.edone = edone;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        ret_t        r;
        logic [15:0] cw, dw, ed;
        logic        ecv, edv, egnt;
        @(posedge clk);
        #1;
        cyc++;
        cw        = 16'hC000 | 16'(cyc);
        dw        = 16'hD000 | 16'(cyc);
        rst       = v.rst;
        cpu_req   = v.creq;
        cpu_we    = v.cwe;
        cpu_addr  = v.caddr;
        cpu_wdata = cw;
        dma_req   = v.dreq;
        dma_we    = v.dwe;
        dma_base  = v.dbase;
        dma_len   = v.dlen;
        dma_wdata = dw;
        #3;
        ecv = 1'b0;
        edv = 1'b0;
        ed  = '0;
        if (v.rst) begin
            sb.delete();
        end else if (sb.size() != 0 && sb[0].cyc == cyc - 1) begin
            r = sb.pop_front();
            if (r.own_dma) edv = 1'b1;
            else           ecv = 1'b1;
            ed = r.data;
        end
        chk("cpu_rvalid", 16'(cpu_rvalid), 16'(ecv));
        chk("dma_rvalid", 16'(dma_rvalid), 16'(edv));
        if (ecv) chk("cpu_rdata", cpu_rdata, ed);
        if (edv) chk("dma_rdata", dma_rdata, ed);
        egnt = v.ecg | v.edg;
        chk("cpu_gnt",   16'(cpu_gnt),   16'(v.ecg));
        chk("dma_gnt",   16'(dma_gnt),   16'(v.edg));
        chk("mem_re",    16'(mem_re),    16'(egnt & ~v.ewe));
        chk("mem_we",    16'(mem_we),    16'(egnt & v.ewe));
        chk("cpu_stall", 16'(cpu_stall), 16'(v.creq & ~v.ecg));
        chk("dma_done",  16'(dma_done),  16'(v.edone));
        if (egnt) chk("mem_addr", mem_addr, v.eaddr);
        if (egnt & v.ewe) chk("mem_wdata", mem_wdata, v.ecg ? cw : dw);
        if (egnt & ~v.ewe) sb.push_back('{v.edg, mdl(v.eaddr), cyc});
    endtask

    initial begin
        logic dturn, prev_d;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_base = '0; dma_len = '0; dma_wdata = '0;

        //           rst creq cwe caddr     dreq dwe dbase     len   ecg edg eaddr     ewe done
        tbl.push_back(mk(1, 1, 0, 16'h0010, 1, 0, 16'h0100, 4'd3, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 4'd0, 0, 0, 16'h0000, 0, 0));
        // CPU read then write
        tbl.push_back(mk(0, 1, 0, 16'h0010, 0, 0, 16'h0000, 4'd0, 1, 0, 16'h0010, 0, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 4'd0, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 1, 1, 16'h0020, 0, 0, 16'h0000, 4'd0, 1, 0, 16'h0020, 1, 0));
        // DMA write burst 0100..0103 with the CPU stalled
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 16'h0100, 4'd3, 0, 1, 16'h0100, 1, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0030, 1, 1, 16'h0100, 4'd3, 0, 1, 16'h0101, 1, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0030, 1, 1, 16'h0100, 4'd3, 0, 1, 16'h0102, 1, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0030, 1, 1, 16'h0100, 4'd3, 0, 1, 16'h0103, 1, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0030, 0, 0, 16'h0000, 4'd0, 1, 0, 16'h0030, 0, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 4'd0, 0, 0, 16'h0000, 0, 0));
        // DMA read burst wrapping FFFE, FFFF, 0000
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 16'hFFFE, 4'd2, 0, 1, 16'hFFFE, 0, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 16'hFFFE, 4'd2, 0, 1, 16'hFFFF, 0, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 16'hFFFE, 4'd2, 0, 1, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 4'd0, 0, 0, 16'h0000, 0, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 4'd0, 0, 0, 16'h0000, 0, 0));
        // single-beat DMA read (len 0)
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 16'h0200, 4'd0, 0, 1, 16'h0200, 0, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 4'd0, 0, 0, 16'h0000, 0, 1));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Continuous tie, single-beat writes; last IDLE winner so far was DMA.
        prev_d = 1'b0;
        for (int k = 0; k < 6; k++) begin
            dturn = RR && (k % 2 == 1);
            apply(mk(0, 1, 1, 16'h0060, 1, 1, 16'h0500, 4'd0,
                     !dturn, dturn, dturn ? 16'h0500 : 16'h0060, 1, prev_d));
            prev_d = dturn;
        end
        apply(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 4'd0, 0, 0, 16'h0000, 0, prev_d));

        // Abort: 5-beat write burst, dma_req dropped after 2 beats.
        apply(mk(0, 0, 0, 16'h0000, 1, 1, 16'h0300, 4'd4, 0, 1, 16'h0300, 1, 0));
        apply(mk(0, 1, 0, 16'h0040, 1, 1, 16'h0300, 4'd4, 0, 1, 16'h0301, 1, 0));
        apply(mk(0, 1, 0, 16'h0040, 0, 0, 16'h0000, 4'd0, 0, 0, 16'h0000, 0, 0));
        apply(mk(0, 1, 0, 16'h0040, 0, 0, 16'h0000, 4'd0, 1, 0, 16'h0040, 0, 0));
        apply(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 4'd0, 0, 0, 16'h0000, 0, 0));

        // Reset on beat 1 of a read burst, then a tie right after release.
        apply(mk(0, 0, 0, 16'h0000, 1, 0, 16'h0400, 4'd3, 0, 1, 16'h0400, 0, 0));
        apply(mk(1, 1, 0, 16'h0000, 1, 0, 16'h0400, 4'd3, 0, 0, 16'h0000, 0, 0));
        apply(mk(0, 1, 1, 16'h0050, 1, 1, 16'h0400, 4'd0, 1, 0, 16'h0050, 1, 0));
        apply(mk(0, 0, 0, 16'h0000, 1, 0, 16'h0400, 4'd0, 0, 1, 16'h0400, 0, 0));
        apply(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 4'd0, 0, 0, 16'h0000, 0, 1));
        apply(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 4'd0, 0, 0, 16'h0000, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 16, address width; DATA_W, 16, data width; LEN_W, 4, DMA burst-length field width.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req / cpu_we  in  1/1  MEM-stage access request / write select.
- cpu_addr, cpu_wdata  in  ADDR_W, DATA_W  CPU address and write data.
- cpu_gnt  out  1  CPU access issued to memory this cycle.
- cpu_stall  out  1  cpu_req & ~cpu_gnt.
- cpu_rdata / cpu_rvalid  out  DATA_W/1  CPU read return.
- dma_req / dma_we  in  1/1  burst request / burst direction.
- dma_base, dma_len  in  ADDR_W, LEN_W  start address; beats minus one.
- dma_wdata  in  DATA_W  write data for the current beat.
- dma_gnt  out  1  DMA beat issued this cycle.
- dma_rdata / dma_rvalid  out  DATA_W/1  DMA read return.
- dma_done  out  1  one-cycle burst-complete pulse.
- mem_re, mem_we  out  1/1  data-memory controls.
- mem_addr, mem_wdata  out  ADDR_W, DATA_W  data-memory address and write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_re.

Function
REQ-003 FSM states SHALL be IDLE and BURST; only one memory access per cycle.
REQ-004 Grants SHALL be combinational in the issue cycle. mem_re = granted & ~we; mem_we = granted & we. mem_addr and mem_wdata SHALL come from the granted requester.
REQ-005 In IDLE with only cpu_req high, the CPU SHALL be granted and the FSM SHALL stay in IDLE (single beat).
REQ-006 In IDLE with a DMA win, the arbiter SHALL:
- issue beat 0 at dma_base;
- latch dma_base, dma_we and dma_len;
- enter BURST if dma_len != 0, else stay in IDLE.
REQ-007 In BURST the arbiter SHALL issue one DMA beat per cycle at latched_base + beat index, with dma_gnt high and the CPU locked out (cpu_stall = cpu_req).
REQ-008 DMA address arithmetic SHALL be modulo 2^ADDR_W (16'hFFFF + 1 -> 16'h0000).
REQ-009 After the beat with index dma_len is issued, the FSM SHALL return to IDLE. dma_done SHALL pulse the following cycle, aligned with the final dma_rvalid on reads.
REQ-010 If dma_req deasserts in BURST, the arbiter SHALL:
- issue no beat that cycle;
- return to IDLE;
- not pulse dma_done.
Returns for already-issued beats SHALL still be delivered.
REQ-011 For each read issued in cycle N, the arbiter SHALL:
- raise the owner's rvalid in cycle N+1;
- drive owner rdata = mem_rdata in cycle N+1;
- hold the other requester's rvalid low.
A one-bit owner/valid pipeline register SHALL track this.
REQ-012 When the CPU and DMA request simultaneously in IDLE, the winner SHALL be chosen per REQ-016.
REQ-013 Requesters SHALL hold request fields stable until granted; the arbiter SHALL NOT buffer requests.

Reset
REQ-014 While rst is high, all grants, mem_re, mem_we, rvalids and dma_done SHALL be 0, and cpu_stall SHALL equal cpu_req.
REQ-015 On reset the FSM SHALL go to IDLE, the beat counter and address SHALL clear, in-flight returns SHALL be discarded, and the last-winner SHALL be set to DMA, so the CPU wins the first tie. Reset mid-burst SHALL abort the burst without dma_done.

Configuration
REQ-016 With DM_ARB_RR_EN defined, ties in IDLE SHALL go to the requester that did not win the previous arbitration. Without it, the CPU SHALL always win ties, and no last-winner register SHALL be built.

Structure
REQ-017 Package dm_arb_pkg SHALL hold ADDR_W/DATA_W/LEN_W defaults, the state enum (IDLE, BURST) and the owner enum (OWN_CPU, OWN_DMA).
REQ-018 Sub-module dm_burst_agen SHALL hold the burst counter and address incrementer, with load, step, last-beat and address outputs.
REQ-019 Target size SHALL be 120-400 lines of RTL.

Verification
REQ-020 The bench SHALL cover:
- CPU read only: cpu_req=1, we=0, addr=16'h0010 -> cpu_gnt the same cycle, mem_re=1, cpu_rvalid next cycle with mem_rdata.
- DMA write burst: base=16'h0100, len=3 -> dma_gnt for 4 cycles at 16'h0100..0103, mem_we each cycle, dma_done one cycle after the last beat, cpu_stall high throughout with cpu_req=1.
- Wrap: DMA read, base=16'hFFFE, len=2 -> addresses FFFE, FFFF, 0000; 3 dma_rvalid pulses; dma_done aligned with the last one.
- Tie with DM_ARB_RR_EN: both request continuously, len=0 -> grants alternate CPU, DMA, CPU, ...; without the macro, CPU every cycle.
- Abort: dma_req dropped after 2 of 5 beats -> FSM in IDLE, no dma_done, CPU granted the next cycle.
- Reset mid-burst: rst=1 on beat 1 -> grants, valids and dma_done low the same cycle, IDLE after release, CPU wins the first tie.
